display_refresh_scheduler: RTL
==============================

# display_refresh_scheduler

Refresh scheduler for the dual seven-segment display. It time-multiplexes two 4-bit digit values onto one shared hex-to-segment decoder. It drives the two active-low anode enables with a programmable blanking (dead-time) interval around every switch, which prevents ghosting. It sits between the digit sources (dip switches or arithmetic results) and the segment decoder at the top level, and replaces ad-hoc toggling logic.

## Interface
- `ON_CYCLES`, default 24000: clock cycles each digit is lit. Must be ≥ 2.
- `DEAD_CYCLES`, default 480: clock cycles both anodes are off before each digit is lit. Must be ≥ 1.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: refresh enable. When low, the display is blanked and the scheduler is held.
- `digit0` input 4: value for the right digit (anode 0).
- `digit1` input 4: value for the left digit (anode 1).
- `hex` output 4: nibble to the shared segment decoder.
- `an0` output 1: anode 0 enable, active low.
- `an1` output 1: anode 1 enable, active low.
- `digit_sel` output 1: 0 while the digit0 slot is active (DEAD0/SHOW0), 1 during DEAD1/SHOW1.
- `frame_tick` output 1: one-cycle pulse at the start of each frame.

## Operation
- There are four states: DEAD0 → SHOW0 → DEAD1 → SHOW1 → DEAD0.
- One down-free up-counter `cnt` is used. Its width is clog2(max(ON_CYCLES, DEAD_CYCLES)).
- `cnt` clears on every state transition and increments otherwise.
- DEADn exits when cnt == DEAD_CYCLES-1. SHOWn exits when cnt == ON_CYCLES-1.
- Every output is a register, updated on the same edge as the state register. Outputs are never decoded combinationally, so there are no glitches on the anodes.
- Output values in each state:
  - DEAD0: an0=1, an1=1, digit_sel=0.
  - SHOW0: an0=0, an1=1, digit_sel=0.
  - DEAD1: an0=1, an1=1, digit_sel=1.
  - SHOW1: an0=1, an1=0, digit_sel=1.
- Both anodes are never low in the same cycle, under any input sequence.
- `hex` loading:
  - In every DEAD cycle, `hex` reloads from the digit for that slot.
  - During SHOW, `hex` is frozen. Input changes while a digit is lit therefore never tear the displayed value.
  - A new value appears at that digit's next DEAD interval.
- `frame_tick` is 1 for exactly the first cycle of DEAD0 reached from SHOW1. It is not asserted on the DEAD0 entry after reset or after `en` rising.
- `en` low:
  - On the next edge the state goes to DEAD0, cnt=0, an0=an1=1, digit_sel=0.
  - The block holds there, with cnt held at 0, for as long as `en` stays low.
  - `hex` keeps tracking `digit0`.
- `en` rising: counting resumes from DEAD0, cnt=0.
- Reset:
  - Values: state=DEAD0, cnt=0, an0=1, an1=1, hex=4'h0, digit_sel=0, frame_tick=0.
  - Reset dominates `en`.
  - Reset asserted in any state takes effect at the next edge. Timing restarts from scratch.
- Simultaneous events: reset > en low > counter terminal transition.

## Timing
- Let edge 0 be the first rising edge with reset=0 and en=1.
- Within each frame, D=DEAD_CYCLES and N=ON_CYCLES:
  - `an0` falls at edge D and rises at edge D+N.
  - `an1` falls at edge 2D+N and rises at edge 2D+2N.
  - `frame_tick` is high in the cycle after edge 2D+2N.
- Frame period is 2·(D+N) cycles.
- Defaults at 48 MHz give 24480 cycles per digit slot, about 980 Hz per frame.
- `hex` holds the new digit at least D cycles before its anode falls, which gives the decoder settle time.
- Latency from a digit input change to display is at most 2·(D+N)+1 cycles.
- Latency from `en` low to both anodes off is 1 cycle.

## Test plan
Benches use ON_CYCLES=4 and DEAD_CYCLES=2 unless stated.
- **Reset:** hold reset high for 3 cycles with en=1, digit0=4'h3 → an0=an1=1, hex=0, digit_sel=0, frame_tick=0 on every cycle.
- **Free run:** digit0=4'h3, digit1=4'hA, en=1.
  - an0=0 on cycles 2–5 with hex=3.
  - an1=0 on cycles 8–11 with hex=A.
  - frame_tick high on cycles 12, 24, 36.
  - An assertion that an0|an1 is never 0 holds for 1000 cycles.
- **Mid-SHOW change:** digit0 goes 3→7 at cycle 3 → hex stays 3 through cycle 5. hex=7 during the next SHOW0 (cycles 14–17).
- **Enable drop:** deassert en during SHOW1 (cycle 9) for 5 cycles.
  - Anodes are both high from cycle 10.
  - No frame_tick pulse.
  - After re-enable, an0 falls exactly 2 cycles later.
- **Reset mid-operation:** assert reset for 1 cycle at cycle 4 (SHOW0) → reset values on the next cycle. The sequence then restarts as in the free-run scenario.
- **Boundary:** DEAD_CYCLES=1, ON_CYCLES=2 → frame period 6. an0 low on cycles 1–2, an1 low on cycles 4–5. No overlap of an0 and an1.

Source files
------------

// File: rtl/display_refresh_scheduler.sv
// Dual seven-segment refresh scheduler.
// Time-multiplexes two digits onto one decoder with blanking between slots.
module display_refresh_scheduler #(
    parameter int ON_CYCLES   = 24000,
    parameter int DEAD_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [3:0] hex,
    output logic       an0,
    output logic       an1,
    output logic       digit_sel,
    output logic       frame_tick
);

    localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] L_DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] L_ON_LAST   = CW'(ON_CYCLES - 1);

    typedef enum logic [1:0] {
        DEAD0,
        SHOW0,
        DEAD1,
        SHOW1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_run;
    logic [3:0]      r_hex;
    logic            r_an0;
    logic            r_an1;
    logic            r_sel;
    logic            r_tick;

    logic            w_dead_last;
    logic            w_on_last;

    assign w_dead_last = (r_cnt == L_DEAD_LAST);
    assign w_on_last   = (r_cnt == L_ON_LAST);

    assign hex        = r_hex;
    assign an0        = r_an0;
    assign an1        = r_an1;
    assign digit_sel  = r_sel;
    assign frame_tick = r_tick;

    // State, slot counter and all outputs advance together on one edge.
    // r_run marks that the first enabled edge after reset or en-low has
    // been spent entering DEAD0, so that edge counts as the slot entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DEAD0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_hex   <= 4'h0;
            r_an0   <= 1'b1;
            r_an1   <= 1'b1;
            r_sel   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (!en || !r_run) begin
            r_state <= DEAD0;
            r_cnt   <= '0;
            r_run   <= en;
            r_hex   <= digit0;
            r_an0   <= 1'b1;
            r_an1   <= 1'b1;
            r_sel   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            unique case (r_state)
                DEAD0: begin
                    if (w_dead_last) begin
                        r_state <= SHOW0;
                        r_cnt   <= '0;
                        r_an0   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_hex <= digit0;
                    end
                end
                SHOW0: begin
                    if (w_on_last) begin
                        r_state <= DEAD1;
                        r_cnt   <= '0;
                        r_an0   <= 1'b1;
                        r_sel   <= 1'b1;
                        r_hex   <= digit1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DEAD1: begin
                    if (w_dead_last) begin
                        r_state <= SHOW1;
                        r_cnt   <= '0;
                        r_an1   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_hex <= digit1;
                    end
                end
                SHOW1: begin
                    if (w_on_last) begin
                        r_state <= DEAD0;
                        r_cnt   <= '0;
                        r_an1   <= 1'b1;
                        r_sel   <= 1'b0;
                        r_hex   <= digit0;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
